// File: rtl/trit_word_preparer.sv
// Serializes a packed word of two-bit trit states, LSB trit first, over a
// valid/ready link; rejects words with an illegal code and counts UNSTABLE trits.
module trit_word_preparer #(
  parameter int NUM_TRITS = 8,
  parameter int CNT_W     = $clog2(NUM_TRITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*NUM_TRITS-1:0]        in_word,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [1:0]                    tx_state,
  output logic [$clog2(NUM_TRITS)-1:0]  tx_index,
  output logic                          tx_last,
  output logic                          word_done,
  output logic [CNT_W-1:0]              unstable_count,
  output logic                          word_err
);

  localparam int IDX_W = $clog2(NUM_TRITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRITS - 1);
  localparam logic [1:0] UNSTABLE = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2*NUM_TRITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       ucount_q, ucount_d;
  logic                   word_err_q, word_err_d;
  logic [NUM_TRITS-1:0]   illegal;
  logic                   is_unstable;

  // A trit is illegal only when both of its bits are set (2'b11).
  generate
    for (genvar gi = 0; gi < NUM_TRITS; gi++) begin : g_illegal
      assign illegal[gi] = in_word[2*gi+1] & in_word[2*gi];
    end
  endgenerate

  assign is_unstable = (shift_q[1:0] == UNSTABLE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    index_d    = index_q;
    count_d    = count_q;
    ucount_d   = ucount_q;
    word_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|illegal) begin
            word_err_d = 1'b1;
          end else begin
            shift_d = in_word;
            index_d = '0;
            count_d = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          count_d = count_q + {{(CNT_W-1){1'b0}}, is_unstable};
          shift_d = {2'b00, shift_q[2*NUM_TRITS-1:2]};
          if (index_q == LAST_IDX) begin
            // Last trit leaves SEND instead of wrapping the index.
            ucount_d = count_d;
            state_d  = DONE;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      index_q    <= '0;
      count_q    <= '0;
      ucount_q   <= '0;
      word_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      index_q    <= index_d;
      count_q    <= count_d;
      ucount_q   <= ucount_d;
      word_err_q <= word_err_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign tx_valid       = (state_q == SEND);
  assign tx_state       = tx_valid ? shift_q[1:0] : 2'b00;
  assign tx_index       = tx_valid ? index_q : '0;
  assign tx_last        = tx_valid && (index_q == LAST_IDX);
  assign word_done      = (state_q == DONE);
  assign unstable_count = ucount_q;
  assign word_err       = word_err_q;

endmodule

// File: tb/tb_trit_word_preparer.sv
// Directed and randomized checks of trit_word_preparer (NUM_TRITS=4) against
// a per-word reference model of trit order, counts and error detection.
module tb_trit_word_preparer;

  localparam int N = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2*N-1:0] in_word;
  logic         tx_valid;
  logic         tx_ready;
  logic [1:0]   tx_state;
  logic [1:0]   tx_index;
  logic         tx_last;
  logic         word_done;
  logic [CW-1:0] unstable_count;
  logic         word_err;

  int n_cmp = 0;
  int n_bad = 0;

  trit_word_preparer #(.NUM_TRITS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_state(tx_state),
    .tx_index(tx_index), .tx_last(tx_last), .word_done(word_done),
    .unstable_count(unstable_count), .word_err(word_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: trit k of a word, and whether a word carries code 2'b11.
  function automatic int trit_of(input logic [2*N-1:0] w, input int k);
    return int'((w >> (2 * k)) & 8'h3);
  endfunction

  function automatic bit has_illegal(input logic [2*N-1:0] w);
    for (int k = 0; k < N; k++) if (trit_of(w, k) == 3) return 1'b1;
    return 1'b0;
  endfunction

  // Offers one word at the current negedge and follows it to completion.
  // On return (legal word) the bench sits in the first in_ready cycle after
  // word_done; nv/nw are what upstream drives after acceptance.
  task automatic run_word(input logic [2*N-1:0] w, input int stall_k, input int stall_n,
                          input int max_rand, input bit nv, input logic [2*N-1:0] nw);
    int cnt;
    int stalls;
    int st;
    in_valid = 1'b1;
    in_word  = w;
    check("accept_ready", in_ready, 1);
    step();
    in_valid = nv;
    in_word  = nw;
    if (has_illegal(w)) begin
      check("err_pulse", word_err, 1);
      check("err_no_tx", tx_valid, 0);
      check("err_ready", in_ready, 1);
      $display("word %02h rejected", w);
      if (!nv) begin
        step();
        check("err_one_cycle", word_err, 0);
        check("err_idle_tx", tx_valid, 0);
      end
      return;
    end
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      st = trit_of(w, k);
      stalls = (k == stall_k) ? stall_n : int'($urandom_range(0, max_rand));
      for (int s = 0; s <= stalls; s++) begin
        tx_ready = (s == stalls);
        check("tx_valid", tx_valid, 1);
        check("tx_state", tx_state, st);
        check("tx_index", tx_index, k);
        check("tx_last", tx_last, (k == N - 1));
        check("send_ready", in_ready, 0);
        check("send_done", word_done, 0);
        step();
      end
      if (st == 2) cnt++;
    end
    tx_ready = 1'($urandom);
    check("done_pulse", word_done, 1);
    check("done_count", unstable_count, cnt);
    check("done_tx", tx_valid, 0);
    check("done_ready", in_ready, 0);
    check("done_no_err", word_err, 0);
    step();
    check("after_done", word_done, 0);
    check("count_hold", unstable_count, cnt);
    check("after_tx", tx_valid, 0);
    check("ready_back", in_ready, 1);
    $display("word %02h done unstable_count=%0d expected=%0d", w, unstable_count, cnt);
  endtask

  initial begin
    logic [2*N-1:0] w;
    logic [2*N-1:0] w2;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; tx_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_state", tx_state, 0);
    check("rst_tx_index", tx_index, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_done", word_done, 0);
    check("rst_err", word_err, 0);
    check("rst_count", unstable_count, 0);
    check("rst_ready", in_ready, 1);

    // Basic serialization, illegal word, then a legal all-POSITIVE word.
    run_word(8'b10_01_00_10, -1, 0, 0, 1'b0, '0);
    run_word(8'b00_11_00_00, -1, 0, 0, 1'b0, '0);
    run_word(8'h00, -1, 0, 0, 1'b0, '0);
    // Backpressure on trit 1 and maximum count.
    run_word(8'b01_10_10_00, 1, 3, 0, 1'b0, '0);
    run_word(8'b10_10_10_10, -1, 0, 0, 1'b0, '0);

    // Reset while trit 2 is pending.
    in_valid = 1'b1; in_word = 8'b10_10_10_10; tx_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("mid_index", tx_index, 2);
    rst = 1'b1; tx_ready = 1'b0;
    step();
    check("mid_rst_tx", tx_valid, 0);
    check("mid_rst_done", word_done, 0);
    check("mid_rst_count", unstable_count, 0);
    rst = 1'b0;
    step();
    check("mid_rel_tx", tx_valid, 0);
    check("mid_rel_done", word_done, 0);
    check("mid_rel_ready", in_ready, 1);
    $display("reset mid-word: tx_valid=%0d in_ready=%0d", tx_valid, in_ready);
    run_word(8'b01_01_01_01, -1, 0, 0, 1'b0, '0);

    // Back-to-back words with in_valid held high.
    run_word(8'b10_00_01_10, -1, 0, 0, 1'b1, 8'b00_10_10_01);
    run_word(8'b00_10_10_01, -1, 0, 1, 1'b0, '0);

    // Randomized words, stalls and back-to-back chaining.
    w = 8'($urandom);
    for (int i = 0; i < 30; i++) begin
      w2 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) w2 = w2 & 8'h55;
      if (has_illegal(w)) run_word(w, -1, 0, 2, 1'b0, '0);
      else run_word(w, -1, 0, 2, 1'($urandom), w2);
      w = w2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trit_word_preparer.md
Name: trit_word_preparer

Overview:
- Transmit-side counterpart of the trinary resolver.
- Accepts a packed word of NUM_TRITS two-bit trit states from upstream over a valid/ready handshake and rejects words containing an illegal code.
- Serializes legal words, least-significant trit first, one trit per handshake toward a resolver array; each trit's state drives a resolver's initial_state.
- Counts UNSTABLE trits issued per word and reports a per-word completion pulse carrying that count.

Parameters:
- NUM_TRITS, 8, trits per input word (≥2).
- CNT_W, $clog2(NUM_TRITS+1), width of unstable_count.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_word  input  2*NUM_TRITS  packed trits; trit k = in_word[2k+1:2k]
- tx_valid  output  1  trit on tx_state is valid
- tx_ready  input  1  downstream accepts trit
- tx_state  output  2  trit code: 2'b00 POSITIVE, 2'b01 NEGATIVE, 2'b10 UNSTABLE
- tx_index  output  $clog2(NUM_TRITS)  position of the current trit
- tx_last  output  1  current trit is index NUM_TRITS-1
- word_done  output  1  one-cycle pulse after the last trit handshake
- unstable_count  output  CNT_W  UNSTABLE trits in the finished word; valid while word_done=1
- word_err  output  1  one-cycle pulse: offered word rejected

Behaviour:
- Encodings: 2'b00 POSITIVE, 2'b01 NEGATIVE, 2'b10 UNSTABLE, 2'b11 ILLEGAL.
- Reset (rst high at a clk edge):
  - State goes to IDLE and any in-flight word is abandoned with no word_done.
  - Shift register, index and counter clear to 0.
  - Registered outputs after reset: tx_valid=0, tx_state=0, tx_index=0, tx_last=0, word_done=0, word_err=0, unstable_count=0.
  - in_ready=1 in the first cycle after reset is released.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - in_ready=1, tx_valid=0.
  - On in_valid & in_ready with no ILLEGAL trit: latch in_word, index←0, count←0, go to SEND.
  - On in_valid & in_ready with any ILLEGAL trit: word_err=1 in the next cycle, word discarded, stay in IDLE (in_ready remains 1).
- SEND:
  - in_ready=0, tx_valid=1.
  - tx_state = shift[1:0], tx_index = index, tx_last = (index == NUM_TRITS-1).
  - While tx_ready=0, all tx_* outputs hold stable.
  - On tx_valid & tx_ready: if tx_state == UNSTABLE then count += 1; shift right by 2; index += 1.
  - If the handshake occurred with tx_last=1, go to DONE.
- DONE:
  - One cycle: word_done=1, unstable_count = final count, tx_valid=0, in_ready=0.
  - Next state IDLE.
  - unstable_count holds its value until the next word_done or reset.
- Latency with tx_ready held at 1, word accepted at edge N:
  - Trit 0 presented in cycle N+1.
  - Trit k presented in cycle N+1+k.
  - word_done in cycle N+1+NUM_TRITS.
  - in_ready=1 again in cycle N+2+NUM_TRITS.
- Counter arithmetic: never exceeds NUM_TRITS, so it cannot overflow CNT_W.
- Index wrap: index is not incremented past NUM_TRITS-1; the last handshake exits SEND instead.
- in_valid while in_ready=0 is ignored; upstream holds the word under standard valid/ready rules.
- word_err and word_done are never asserted in the same cycle.
- Reset has priority over every other event in the same cycle.

Test Plan (NUM_TRITS=4, CNT_W=3):
- Basic serialization: in_word=8'b10_01_00_10, tx_ready=1 → tx_state sequence 10,00,01,10 with tx_index 0..3 and tx_last only at index 3; word_done one cycle later with unstable_count=2; in_ready back to 1 the following cycle.
- Illegal word: in_word=8'b00_11_00_00 → word_err pulses for one cycle, tx_valid never asserts, in_ready stays 1; a following legal word 8'h00 serializes four POSITIVE trits with unstable_count=0.
- Backpressure: in_word=8'b01_10_10_00, tx_ready low for 3 cycles on trit 1 → tx_state=10 and tx_index=1 hold stable throughout; sequence completes 00,10,10,01 with unstable_count=2.
- Maximum count: in_word=8'b10_10_10_10 → four UNSTABLE trits issued, unstable_count=4 with no overflow.
- Reset mid-operation: assert rst while trit 2 is pending → next cycle tx_valid=0, no word_done, in_ready=1 after release; a new word 8'b01_01_01_01 serializes from index 0 with unstable_count=0.
- Back-to-back words: in_valid held high with two legal words → the second is accepted exactly in the cycle after the first word_done, with no trit lost or duplicated.
